// File: rtl/xsimbus_arbiter_pkg.sv
// xsimbus arbiter shared definitions.
// Bus master count, id width, watchdog limit, FSM states.
package xsimbus_arbiter_pkg;

  localparam int BusMasterNum  = 4;
  localparam int BusMasterIdW  = 2;
  localparam int BusArbTimeout = 16;
  localparam int BusArbCntW    = 8;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbOwn  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/xsimbus_arbiter_rr_pick.sv
// Round-robin winner selection for the xsimbus arbiter.
// Scans upward from last+1, wrapping modulo MASTERS.
module xsimbus_rr_pick
  import xsimbus_arbiter_pkg::*;
#(
  parameter int MASTERS = BusMasterNum,
  parameter int ID_W    = BusMasterIdW
) (
  input  logic [MASTERS-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               any,
  output logic [ID_W-1:0]    win_id,
  output logic [MASTERS-1:0] win_onehot
);

  logic            found;
  logic [ID_W-1:0] sel;

  always_comb begin
    any        = |req;
    win_id     = '0;
    win_onehot = '0;
    found      = 1'b0;
    sel        = '0;
    for (int i = 1; i <= MASTERS; i++) begin
      sel = ID_W'((int'(last) + i) % MASTERS);
      if (!found && req[sel]) begin
        found  = 1'b1;
        win_id = sel;
      end
    end
    if (found) begin
      win_onehot[win_id] = 1'b1;
    end
  end

endmodule

// File: rtl/xsimbus_arbiter.sv
// Round-robin xsimbus arbiter with lock hold and ack watchdog.
// Registered one-hot grant plus master-select index for the mux.
module xsimbus_arbiter
  import xsimbus_arbiter_pkg::*;
#(
  parameter int MASTERS = BusMasterNum,
  parameter int ID_W    = BusMasterIdW,
  parameter int TIMEOUT = BusArbTimeout
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MASTERS-1:0] req,
  input  logic [MASTERS-1:0] lock,
  input  logic               bus_ack,
  output logic [MASTERS-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               bus_busy,
  output logic               timeout_err
);

  arb_state_e             state_q, state_d;
  logic [MASTERS-1:0]     gnt_q, gnt_d;
  logic [ID_W-1:0]        gnt_id_q, gnt_id_d;
  logic                   busy_q, busy_d;
  logic                   terr_q, terr_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [BusArbCntW-1:0]  cnt_q, cnt_d;

  logic                   pick_any;
  logic [ID_W-1:0]        pick_id;
  logic [MASTERS-1:0]     pick_oh;
  logic                   rel;
  logic                   do_grant;

  xsimbus_rr_pick #(
    .MASTERS (MASTERS),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (req),
    .last       (last_q),
    .any        (pick_any),
    .win_id     (pick_id),
    .win_onehot (pick_oh)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    terr_d   = 1'b0;
    last_d   = last_q;
    cnt_d    = cnt_q;
    rel      = 1'b0;
    do_grant = 1'b0;

    unique case (state_q)
      ArbIdle: begin
        do_grant = pick_any;
      end
      ArbOwn: begin
        if (!req[gnt_id_q]) begin
          rel = 1'b1;
        end else if (bus_ack && lock[gnt_id_q]) begin
          cnt_d = '0;
        end else if (bus_ack) begin
          rel = 1'b1;
        end else if (cnt_q == BusArbCntW'(TIMEOUT - 1)) begin
          rel    = 1'b1;
          terr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // last_q == owner, so the owner ranks lowest on re-arbitration
        if (rel) begin
          do_grant = pick_any;
          if (!pick_any) begin
            state_d = ArbIdle;
            gnt_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ArbIdle;
      end
    endcase

    if (do_grant) begin
      state_d  = ArbOwn;
      gnt_d    = pick_oh;
      gnt_id_d = pick_id;
      busy_d   = 1'b1;
      last_d   = pick_id;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ArbIdle;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      last_q   <= ID_W'(MASTERS - 1);
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign bus_busy    = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_xsimbus_arbiter.sv
// Self-checking bench for xsimbus_arbiter: directed cases plus
// randomized traffic compared every cycle against an ownership model.
module tb_xsimbus_arbiter;

  localparam int M  = 4;
  localparam int IW = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [M-1:0]  req;
  logic [M-1:0]  lock;
  logic          bus_ack;
  logic [M-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          bus_busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model: who owns the bus, who won last, cycles waited for an ack
  int m_owner;
  int m_last;
  int m_wait;
  int m_id;
  bit m_terr;

  xsimbus_arbiter #(.MASTERS(M), .ID_W(IW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .lock        (lock),
    .bus_ack     (bus_ack),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [M-1:0] r, input int last);
    for (int k = 1; k <= M; k++) begin
      if (r[(last + k) % M]) return (last + k) % M;
    end
    return -1;
  endfunction

  function automatic logic [M-1:0] exp_gnt();
    logic [M-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  always @(posedge clk) begin
    int w;
    bit release_now;
    if (rst) begin
      m_owner = -1;
      m_last  = M - 1;
      m_wait  = 0;
      m_id    = 0;
      m_terr  = 1'b0;
    end else begin
      m_terr      = 1'b0;
      release_now = 1'b0;
      if (m_owner < 0) begin
        release_now = 1'b1;
      end else if (!req[m_owner]) begin
        release_now = 1'b1;
      end else if (bus_ack) begin
        if (lock[m_owner]) m_wait = 0;
        else release_now = 1'b1;
      end else if (m_wait + 1 >= TO) begin
        release_now = 1'b1;
        m_terr      = 1'b1;
      end else begin
        m_wait++;
      end
      if (release_now) begin
        w = pick(req, m_last);
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
          m_id    = w;
          m_wait  = 0;
        end else begin
          m_owner = -1;
          m_wait  = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_gnt", int'(gnt), int'(exp_gnt()));
      chk("model_gnt_id", int'(gnt_id), m_id);
      chk("model_busy", int'(bus_busy), int'(m_owner >= 0));
      chk("model_terr", int'(timeout_err), int'(m_terr));
      chk("onehot", int'($countones(gnt) <= 1), 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; lock = '0; bus_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0; bus_ack = 1'b0;
    do_reset();
    cmp_en = 1'b1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_id", int'(gnt_id), 0);
    chk("rst_busy", int'(bus_busy), 0);
    chk("rst_terr", int'(timeout_err), 0);

    // single request, then ack with request dropped
    req = 4'b0100;
    step();
    chk("single_gnt", int'(gnt), 4'b0100);
    chk("single_id", int'(gnt_id), 2);
    chk("single_busy", int'(bus_busy), 1);
    req = '0; bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("single_rel_gnt", int'(gnt), 0);
    chk("single_rel_id", int'(gnt_id), 2);
    chk("ack_idle_busy", int'(bus_busy), 0);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("ack_in_idle", int'(gnt), 0);

    // fairness rotation
    do_reset();
    req = 4'b1111;
    step();
    chk("fair_first", int'(gnt_id), 0);
    bus_ack = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("fair_seq", int'(gnt_id), k % 4);
      chk("fair_busy", int'(bus_busy), 1);
    end
    bus_ack = 1'b0;

    // lock burst
    do_reset();
    req = 4'b0010;
    step();
    chk("lock_own", int'(gnt_id), 1);
    req = 4'b0011; lock = 4'b0010; bus_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lock_hold", int'(gnt_id), 1);
    end
    lock = '0;
    step();
    chk("lock_drop", int'(gnt_id), 0);
    bus_ack = 1'b0;

    // watchdog
    do_reset();
    req = 4'b1001;
    step();
    chk("wd_grant", int'(gnt), 4'b0001);
    for (int k = 1; k < TO; k++) begin
      step();
      chk("wd_wait_id", int'(gnt_id), 0);
      chk("wd_wait_terr", int'(timeout_err), 0);
    end
    step();
    chk("wd_next_id", int'(gnt_id), 3);
    chk("wd_terr", int'(timeout_err), 1);
    step();
    chk("wd_terr_pulse", int'(timeout_err), 0);

    // reset mid-burst
    do_reset();
    req = 4'b0100; lock = 4'b0100;
    step();
    bus_ack = 1'b1;
    step();
    chk("mid_own", int'(gnt_id), 2);
    rst = 1'b1;
    step();
    chk("mid_rst_gnt", int'(gnt), 0);
    chk("mid_rst_id", int'(gnt_id), 0);
    rst = 1'b0; bus_ack = 1'b0; lock = '0; req = 4'b1111;
    step();
    chk("mid_after_id", int'(gnt_id), 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      req     = M'($urandom);
      lock    = M'($urandom);
      bus_ack = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) req = req | 4'b0001;
      step();
    end
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xsimbus_arbiter.md
# xsimbus_arbiter

Round-robin bus arbiter that shares the `xsimbus` interconnect between the SoC's bus masters (core fetch, core load/store, future DMA/debug). It sits in front of the `xsimbus` master mux, owns the grant and the master-select index (`who`), and holds ownership across locked multi-beat transfers. A watchdog forces release if a slave never acknowledges.

## Interface
Parameters:
- `MASTERS`, 4: number of requesting masters (2..16)
- `ID_W`, 2: width of master index; must equal ceil(log2(MASTERS)), min 1
- `TIMEOUT`, 16: max cycles an owner may wait for `bus_ack` before forced release (2..255)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  MASTERS  per-master bus request, level
- `lock`  in  MASTERS  per-master: keep ownership after current beat's ack
- `bus_ack`  in  1  slave completed the current beat (1-cycle pulse)
- `gnt`  out  MASTERS  one-hot grant, registered; all-zero when idle
- `gnt_id`  out  ID_W  index of granted master; drives `xsimbus` master mux `who`
- `bus_busy`  out  1  high while any grant is active
- `timeout_err`  out  1  1-cycle pulse on watchdog forced release

## Operation
- States: `IDLE`, `OWN`.
- Reset values: state `IDLE`, `gnt`=0, `gnt_id`=0, `bus_busy`=0, `timeout_err`=0, round-robin pointer `last`=MASTERS-1 (master 0 highest first priority), watchdog counter 0.
- Winner selection: first asserted `req` bit scanning from `last+1` upward, wrapping modulo MASTERS.
- `IDLE`: if any `req`, register winner into `gnt`/`gnt_id`, set `last`=winner, clear counter, go `OWN`. Else stay.
- `OWN`, evaluated each cycle in this priority order:
  1. owner's `req` low (abort): release.
  2. `bus_ack` high and owner's `lock` high and owner's `req` high: stay `OWN`, clear counter.
  3. `bus_ack` high otherwise: release.
  4. counter reaches TIMEOUT-1 with no ack: release, pulse `timeout_err`.
  5. else increment counter.
- Release: if any `req` among non-owner masters, or owner's `req` (owner ranks lowest because `last`=owner), grant the next winner on the following edge (back-to-back handoff, no idle cycle); else go `IDLE`, `gnt`=0, `gnt_id` holds last value.
- Requests from non-owners never preempt a locked owner except via timeout.
- Counter width 8 bits, saturation not needed (bounded by TIMEOUT).

## Timing
- Grant latency: `req` sampled high in `IDLE` at edge N -> `gnt` valid after edge N (visible cycle N+1).
- Handoff: `bus_ack` at edge N (unlocked) -> new owner's `gnt` visible cycle N+1; old owner's bit drops on same edge. `gnt` is never multi-hot.
- Watchdog: owner granted at edge G with no ack -> release at edge G+TIMEOUT; `timeout_err` high exactly one cycle after that edge.
- `bus_ack` while `IDLE` ignored.
- `rst` high on any edge overrides all, including mid-transfer; outputs reach reset values after that edge.
- `bus_busy` = OR of `gnt`, registered alongside it.

## Structure
- Add to `defines.v`: `BusMasterNum` (4), `BusMasterIdBus` (`ID_W-1:0`), `BusArbTimeout` (16), state encodings `ArbIdle`/`ArbOwn`.
- One combinational sub-module `xsimbus_rr_pick`: inputs `req`, `last`; outputs `any`, `win_id`, `win_onehot`. Arbiter core holds FSM, pointer, counter, output registers.

## Test plan
- Reset/idle: `rst`=1 two edges, `req`=0 -> `gnt`=0000, `gnt_id`=0, `bus_busy`=0, `timeout_err`=0.
- Single request: `req`=0100 in `IDLE` -> next cycle `gnt`=0100, `gnt_id`=2; `bus_ack` pulse -> `gnt`=0000 next cycle.
- Fairness: `req`=1111 held, `bus_ack` every cycle, `lock`=0 -> `gnt_id` sequence 0,1,2,3,0,... with no idle cycles.
- Lock burst: owner 1, `lock`=0010, `req`=0011, three acks -> `gnt_id` stays 1; drop `lock`, next ack -> `gnt_id`=0.
- Timeout: `req`=0001, never ack, TIMEOUT=16 -> `gnt` released 16 cycles after grant, `timeout_err` one-cycle pulse; with `req`=1001 held, `gnt_id`=3 next.
- Reset mid-burst: owner 2 locked, assert `rst` -> following cycle `gnt`=0000; after release, `req`=1111 -> `gnt_id`=0.
